// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis ball-flight engine: FSM state codes,
// court side identifiers and the width of the step tick/period counters.
package tennis_pkg;

    localparam int TICK_W = 8;
    typedef logic [TICK_W-1:0] tick_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SERVE  = 2'd1;
    localparam logic [1:0] ST_FLIGHT = 2'd2;
    localparam logic [1:0] ST_DEAD   = 2'd3;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Decrement by one without going below the floor.
    function automatic tick_t sat_dec(input tick_t value, input tick_t floor_v);
        return (value > floor_v) ? (value - tick_t'(1)) : floor_v;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer for ball_court: counts clock cycles per ball step and raises a
// step strobe on the last tick of each period.
// Optional feature macro: BALL_SPEEDUP_EN adds a period register that
// reloads at each serve and shrinks by one on every valid return.
module step_timer
    import tennis_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int MIN_PERIOD = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clear_i,
`ifdef BALL_SPEEDUP_EN
    input  logic load_i,
    input  logic dec_i,
`endif
    output logic step_o
);

    tick_t tick_q, tick_d;
    tick_t period;

`ifdef BALL_SPEEDUP_EN
    tick_t period_q, period_d;

    // Period reloads on serve and speeds up (saturating) on each return.
    always_comb begin
        period_d = period_q;
        if (load_i) begin
            period_d = tick_t'(TICK_DIV);
        end else if (dec_i) begin
            period_d = sat_dec(period_q, tick_t'(MIN_PERIOD));
        end
    end

    // Period register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= tick_t'(TICK_DIV);
        end else begin
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    // The floor applies to any period, so a fixed one honours it as well.
    localparam tick_t FIXED_PERIOD = (TICK_DIV > MIN_PERIOD) ? tick_t'(TICK_DIV)
                                                             : tick_t'(MIN_PERIOD);
    assign period = FIXED_PERIOD;
`endif

    // >= rather than == keeps the counter safe if the period ever shrinks.
    assign step_o = run_i & ~clear_i & (tick_q >= (period - tick_t'(1)));

    // Tick counts 0..period-1 while running; cleared when idle or on a return.
    always_comb begin
        tick_d = tick_q;
        if (!run_i || clear_i) begin
            tick_d = '0;
        end else if (tick_q >= (period - tick_t'(1))) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + tick_t'(1);
        end
    end

    // Tick register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/ball_court.sv
// Ball-flight engine: moves the ball between side A (pos 0) and side B
// (pos COURT_LEN-1), drives the players' hittable flags, takes their return
// pulses, flags misses and re-serves while the game runs.
// Optional feature macro: BALL_SPEEDUP_EN (ball speeds up on every return).
module ball_court
    import tennis_pkg::*;
#(
    parameter  int COURT_LEN  = 8,
    parameter  int HIT_ZONE   = 2,
    parameter  int TICK_DIV   = 4,
    parameter  int MIN_PERIOD = 1,
    localparam int PW         = $clog2(COURT_LEN)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_game_i,
    input  logic          match_a_i,
    input  logic          match_b_i,
    input  logic          return_a_i,
    input  logic          return_b_i,
    output logic          hittable_a_o,
    output logic          hittable_b_o,
    output logic          miss_a_o,
    output logic          miss_b_o,
    output logic [PW-1:0] ball_pos_o,
    output logic          ball_dir_o,
    output logic          in_play_o
);

    localparam logic [PW-1:0] POS_LAST   = PW'(COURT_LEN - 1);
    localparam logic [PW-1:0] POS_B_ZONE = PW'(COURT_LEN - HIT_ZONE);
    localparam logic [PW-1:0] POS_A_ZONE = PW'(HIT_ZONE);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          server_q, server_d;
    logic          miss_a_q, miss_a_d;
    logic          miss_b_q, miss_b_d;

    logic stop_req, in_play, ret_valid, off_end, step, timer_run, enter_serve;

    assign stop_req  = ~start_game_i | match_a_i | match_b_i;
    assign in_play   = (state_q == ST_SERVE) || (state_q == ST_FLIGHT);
    assign hittable_a_o = in_play & ~dir_q & (pos_q < POS_A_ZONE);
    assign hittable_b_o = in_play &  dir_q & (pos_q >= POS_B_ZONE);
    // Hittables are exclusive by direction, so at most one return can act.
    assign ret_valid = (state_q == ST_FLIGHT) &
                       ((return_a_i & hittable_a_o) | (return_b_i & hittable_b_o));
    assign off_end   = dir_q ? (pos_q == POS_LAST) : (pos_q == '0);
    assign timer_run = (state_q == ST_FLIGHT) || (state_q == ST_DEAD);

    step_timer #(
        .TICK_DIV   (TICK_DIV),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_step_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .run_i   (timer_run),
        .clear_i (ret_valid),
`ifdef BALL_SPEEDUP_EN
        .load_i  (enter_serve),
        .dec_i   (ret_valid),
`endif
        .step_o  (step)
    );

    // Game FSM and ball position/direction next-state.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        server_d = server_q;
        miss_a_d = 1'b0;
        miss_b_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A fresh game always starts with A serving.
                server_d = SIDE_A;
                state_d  = ST_SERVE;
            end
            ST_SERVE: begin
                state_d = ST_FLIGHT;
            end
            ST_FLIGHT: begin
                // A return beats a simultaneous off-end step.
                if (ret_valid) begin
                    dir_d = ~dir_q;
                end else if (step) begin
                    if (off_end) begin
                        state_d = ST_DEAD;
                        if (dir_q) begin
                            miss_b_d = 1'b1;
                            server_d = SIDE_B;
                        end else begin
                            miss_a_d = 1'b1;
                            server_d = SIDE_A;
                        end
                    end else begin
                        pos_d = dir_q ? (pos_q + PW'(1)) : (pos_q - PW'(1));
                    end
                end
            end
            ST_DEAD: begin
                if (step) begin
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Stopping the game overrides everything; the ball freezes in place.
        if (stop_req) begin
            state_d  = ST_IDLE;
            pos_d    = pos_q;
            dir_d    = dir_q;
            miss_a_d = 1'b0;
            miss_b_d = 1'b0;
        end
        // Ball is placed on entry to SERVE so the serve cycle already shows it.
        enter_serve = (state_d == ST_SERVE);
        if (enter_serve) begin
            pos_d = (server_d == SIDE_B) ? POS_LAST : '0;
            dir_d = (server_d == SIDE_A);
        end
    end

    // State, ball and miss-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            server_q <= SIDE_A;
            miss_a_q <= 1'b0;
            miss_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            server_q <= server_d;
            miss_a_q <= miss_a_d;
            miss_b_q <= miss_b_d;
        end
    end

    assign miss_a_o   = miss_a_q;
    assign miss_b_o   = miss_b_q;
    assign ball_pos_o = pos_q;
    assign ball_dir_o = dir_q;
    assign in_play_o  = in_play;

endmodule

// File: tb/tb_ball_court.sv
// Directed self-checking bench for ball_court (COURT_LEN=8, HIT_ZONE=2,
// TICK_DIV=4). Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_ball_court;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       match_a = 1'b0;
    logic       match_b = 1'b0;
    logic       ret_a = 1'b0;
    logic       ret_b = 1'b0;
    logic       hit_a, hit_b, miss_a, miss_b, dir, in_play;
    logic [2:0] pos;

    int checks = 0;
    int failures = 0;

    ball_court #(
        .COURT_LEN  (8),
        .HIT_ZONE   (2),
        .TICK_DIV   (4),
        .MIN_PERIOD (1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_game_i (start),
        .match_a_i    (match_a),
        .match_b_i    (match_b),
        .return_a_i   (ret_a),
        .return_b_i   (ret_b),
        .hittable_a_o (hit_a),
        .hittable_b_o (hit_b),
        .miss_a_o     (miss_a),
        .miss_b_o     (miss_b),
        .ball_pos_o   (pos),
        .ball_dir_o   (dir),
        .in_play_o    (in_play)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, release with start_game=1, advance to the first FLIGHT cycle (pos 0, tick 0).
    task automatic start_fresh();
        @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b1; match_a = 1'b0; match_b = 1'b0; ret_a = 1'b0; ret_b = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        start = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", dir); end
        checks++; if (in_play !== 1'b0) begin failures++; $display("FAIL reset_in_play got=%b exp=0", in_play); end
        checks++; if ({hit_a, hit_b, miss_a, miss_b} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got=%b exp=0000", {hit_a, hit_b, miss_a, miss_b}); end
        @(posedge clk);
        #1;
        checks++; if (in_play !== 1'b0) begin failures++; $display("FAIL reset_held_in_play got=%b exp=0", in_play); end
        rst_n = 1'b1;
        cyc(1);
        checks++; if ({in_play, pos, dir} !== {1'b1, 3'd0, 1'b1}) begin failures++;
            $display("FAIL serve_state got in_play=%b pos=%0d dir=%b exp 1/0/1", in_play, pos, dir); end
        cyc(1);
        checks++; if ({in_play, pos} !== {1'b1, 3'd0}) begin failures++;
            $display("FAIL flight_start got in_play=%b pos=%0d exp 1/0", in_play, pos); end
        cyc(3);
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL pos_before_step got=%0d exp=0", pos); end
        cyc(1);
        checks++; if (pos !== 3'd1) begin failures++; $display("FAIL pos_first_step got=%0d exp=1", pos); end
        cyc(19);
        checks++; if ({pos, hit_b} !== {3'd5, 1'b0}) begin failures++;
            $display("FAIL pos5_not_hittable got pos=%0d hb=%b exp 5/0", pos, hit_b); end
        cyc(1);
        checks++; if ({pos, hit_b} !== {3'd6, 1'b1}) begin failures++;
            $display("FAIL pos6_hittable got pos=%0d hb=%b exp 6/1", pos, hit_b); end
    endtask

    // Continues from pos 6 of test_reset: B misses, B serves, then A misses, A serves.
    task automatic test_miss();
        cyc(4);
        checks++; if ({pos, hit_b, in_play} !== {3'd7, 1'b1, 1'b1}) begin failures++;
            $display("FAIL pos7 got pos=%0d hb=%b in_play=%b exp 7/1/1", pos, hit_b, in_play); end
        cyc(3);
        checks++; if (miss_b !== 1'b0) begin failures++; $display("FAIL miss_b_early got=%b exp=0", miss_b); end
        cyc(1);
        checks++; if ({miss_b, miss_a, in_play, pos} !== {1'b1, 1'b0, 1'b0, 3'd7}) begin failures++;
            $display("FAIL miss_b_pulse got mb=%b ma=%b in_play=%b pos=%0d exp 1/0/0/7", miss_b, miss_a, in_play, pos); end
        cyc(1);
        checks++; if ({miss_b, in_play} !== 2'b00) begin failures++;
            $display("FAIL miss_b_one_cycle got mb=%b in_play=%b exp 0/0", miss_b, in_play); end
        cyc(2);
        checks++; if (in_play !== 1'b0) begin failures++; $display("FAIL dead_last_cycle got in_play=%b exp=0", in_play); end
        cyc(1);
        checks++; if ({in_play, pos, dir, hit_b} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin failures++;
            $display("FAIL b_serve got in_play=%b pos=%0d dir=%b hb=%b exp 1/7/0/0", in_play, pos, dir, hit_b); end
        cyc(29);
        checks++; if ({pos, hit_a} !== {3'd0, 1'b1}) begin failures++;
            $display("FAIL pos0_hittable_a got pos=%0d ha=%b exp 0/1", pos, hit_a); end
        cyc(4);
        checks++; if ({miss_a, miss_b, in_play, pos} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin failures++;
            $display("FAIL miss_a_pulse got ma=%b mb=%b in_play=%b pos=%0d exp 1/0/0/0", miss_a, miss_b, in_play, pos); end
        cyc(4);
        checks++; if ({in_play, pos, dir} !== {1'b1, 3'd0, 1'b1}) begin failures++;
            $display("FAIL a_serve got in_play=%b pos=%0d dir=%b exp 1/0/1", in_play, pos, dir); end
    endtask

    task automatic test_return();
        start_fresh();
        cyc(24);
        ret_b = 1'b1;
        cyc(1);
        ret_b = 1'b0;
        checks++; if ({dir, pos, hit_b} !== {1'b0, 3'd6, 1'b0}) begin failures++;
            $display("FAIL return_b_flip got dir=%b pos=%0d hb=%b exp 0/6/0", dir, pos, hit_b); end
        cyc(3);
        checks++; if (pos !== 3'd6) begin failures++; $display("FAIL return_tick_cleared got=%0d exp=6", pos); end
        cyc(1);
        checks++; if (pos !== 3'd5) begin failures++; $display("FAIL after_return_step got=%0d exp=5", pos); end
        cyc(8);
        ret_a = 1'b1; ret_b = 1'b1;
        cyc(1);
        ret_a = 1'b0; ret_b = 1'b0;
        checks++; if ({dir, pos} !== {1'b0, 3'd3}) begin failures++;
            $display("FAIL return_outside_zone got dir=%b pos=%0d exp 0/3", dir, pos); end
        cyc(7);
        checks++; if ({pos, hit_a} !== {3'd1, 1'b1}) begin failures++;
            $display("FAIL pos1_hittable_a got pos=%0d ha=%b exp 1/1", pos, hit_a); end
        ret_a = 1'b1; ret_b = 1'b1;
        cyc(1);
        ret_a = 1'b0; ret_b = 1'b0;
        checks++; if ({dir, pos, hit_a} !== {1'b1, 3'd1, 1'b0}) begin failures++;
            $display("FAIL return_a_both_pulses got dir=%b pos=%0d ha=%b exp 1/1/0", dir, pos, hit_a); end
        cyc(4);
        checks++; if (pos !== 3'd2) begin failures++; $display("FAIL after_return_a_step got=%0d exp=2", pos); end
    endtask

    task automatic test_return_at_end();
        start_fresh();
        cyc(31);
        ret_b = 1'b1;
        cyc(1);
        ret_b = 1'b0;
        checks++; if ({miss_b, in_play, dir, pos} !== {1'b0, 1'b1, 1'b0, 3'd7}) begin failures++;
            $display("FAIL return_beats_miss got mb=%b in_play=%b dir=%b pos=%0d exp 0/1/0/7", miss_b, in_play, dir, pos); end
        cyc(4);
        checks++; if (pos !== 3'd6) begin failures++; $display("FAIL after_end_return got=%0d exp=6", pos); end
    endtask

    task automatic test_force_idle();
        start_fresh();
        cyc(24);
        match_a = 1'b1;
        cyc(1);
        checks++; if ({in_play, hit_a, hit_b, pos} !== {3'b000, 3'd6}) begin failures++;
            $display("FAIL match_a_idle got in_play=%b ha=%b hb=%b pos=%0d exp 0/0/0/6", in_play, hit_a, hit_b, pos); end
        cyc(2);
        checks++; if (in_play !== 1'b0) begin failures++; $display("FAIL match_a_holds got in_play=%b exp=0", in_play); end
        match_a = 1'b0;
        cyc(1);
        checks++; if ({in_play, pos, dir} !== {1'b1, 3'd0, 1'b1}) begin failures++;
            $display("FAIL restart_serve got in_play=%b pos=%0d dir=%b exp 1/0/1", in_play, pos, dir); end
        cyc(1);
        start = 1'b0;
        cyc(1);
        checks++; if (in_play !== 1'b0) begin failures++; $display("FAIL start_low_idle got in_play=%b exp=0", in_play); end
        start_fresh();
        cyc(24);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({pos, dir, in_play, hit_b} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin failures++;
            $display("FAIL async_reset got pos=%0d dir=%b in_play=%b hb=%b exp 0/1/0/0", pos, dir, in_play, hit_b); end
    endtask

`ifdef BALL_SPEEDUP_EN
    task automatic test_speedup();
        int exp_p [4] = '{3, 2, 1, 1};
        int n;
        logic [2:0] p0;
        start_fresh();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(hit_a || hit_b) && n < 200) begin cyc(1); n++; end
            checks++; if (n >= 200) begin failures++; $display("FAIL speedup_wait_hittable k=%0d timed out", k); end
            ret_a = hit_a; ret_b = hit_b;
            cyc(1);
            ret_a = 1'b0; ret_b = 1'b0;
            p0 = pos; n = 0;
            while (pos == p0 && n < 20) begin cyc(1); n++; end
            checks++; if (n !== exp_p[k]) begin failures++;
                $display("FAIL speedup_period k=%0d got=%0d exp=%0d", k, n, exp_p[k]); end
        end
        n = 0;
        while (!(miss_a || miss_b) && n < 200) begin cyc(1); n++; end
        while (!in_play && n < 200) begin cyc(1); n++; end
        checks++; if (n >= 200) begin failures++; $display("FAIL speedup_wait_serve timed out"); end
        p0 = pos; n = 0;
        while (pos == p0 && n < 20) begin cyc(1); n++; end
        checks++; if (n !== 5) begin failures++; $display("FAIL speedup_serve_restore got=%0d exp=5", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_miss();
        test_return();
        test_return_at_end();
        test_force_idle();
`ifdef BALL_SPEEDUP_EN
        test_speedup();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
